ad9361_spi_arbiter: RTL and testbench
=====================================

// Module: ad9361_spi_arbiter
// PURPOSE
// - Shares the single AD9361 SPI engine among N_REQ register-access requesters,
//   e.g. the AXI4-Lite register bank, the init-sequence ROM and the gain/AGC tracker.
// - Arbitrates round-robin and builds the 16-bit AD9361 instruction word.
// - Issues one single-byte transaction at a time and returns the read data or a
//   timeout error to the requester that owns the grant.
// PARAMETERS
// - N_REQ           3     number of requester ports (2..8)
// - TIMEOUT_CYCLES  4096  clock cycles in WAIT before a transaction is aborted (>=2)
// PORTS
// - clock       in   1        system clock, single domain
// - reset       in   1        synchronous, active-high
// - req_valid   in   N_REQ    per-port request valid
// - req_ready   out  N_REQ    per-port accept; transfer when valid&ready
// - req_write   in   N_REQ    1=write, 0=read
// - req_addr    in   N_REQ*10 AD9361 register address, port i at [10i+:10]
// - req_wdata   in   N_REQ*8  write byte, port i at [8i+:8]
// - rsp_valid   out  N_REQ    one-cycle response pulse to the owning port
// - rsp_rdata   out  8        read byte (0 for writes/errors), shared by all ports
// - rsp_err     out  1        1 = timeout, qualified by rsp_valid
// - eng_start   out  1        one-cycle launch pulse to the SPI engine
// - eng_instr   out  16       {W/R, 3'b000 (1 byte), 2'b00, addr[9:0]}
// - eng_wdata   out  8        write byte, held stable ISSUE..RESP
// - eng_abort   out  1        one-cycle abort pulse on timeout
// - eng_done    in   1        engine completion pulse
// - eng_rdata   in   8        engine read byte, valid with eng_done
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; last_grant=N_REQ-1, so port 0 wins first; timer=0.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: grant = first asserted req_valid searching from last_grant+1 with wrap.
//   - req_ready[grant]=1 combinationally, other ports 0.
//   - On accept, register write/addr/wdata/port, then go to ISSUE.
//   - With no valid request, stay in IDLE.
// - Valid/ready: a requester must hold valid and its fields stable until ready.
//   Its valid must not depend on ready.
// - ISSUE: eng_start=1 for exactly one cycle with eng_instr/eng_wdata valid.
//   Clear the timer, then go to WAIT.
// - WAIT: the timer increments every cycle.
//   - On eng_done: capture eng_rdata (force 0 for writes), err=0, go to RESP.
//   - If the timer reaches TIMEOUT_CYCLES-1 without done: eng_abort=1 for one cycle,
//     rdata=0, err=1, go to RESP.
//   - eng_done and timeout in the same cycle: done wins, no abort.
// - RESP: rsp_valid[port]=1 for one cycle with rsp_rdata/rsp_err.
//   Set last_grant=port, then go to IDLE. There is no response backpressure.
// - Latency: accept at cycle T; eng_start at T+1; rsp_valid one cycle after eng_done.
//   The earliest next accept is two cycles after eng_done.
// - eng_done in IDLE, ISSUE or RESP is ignored (no state change).
// - rsp_rdata and rsp_err hold their last value between pulses.
// - Reset mid-transaction drops the transaction silently: no rsp_valid, no eng_abort.
//   The engine shares the same reset.
// - Requests arriving while the FSM is busy wait; their ready stays 0.
//   A port never gets two consecutive grants while another port is valid.
// STRUCTURE
// - ad9361_spi_pkg holds:
//   - state enum {IDLE, ISSUE, WAIT, RESP}
//   - instruction field localparams (INSTR_WR_BIT=15, INSTR_CNT_LSB=12, ADDR_W=10, DATA_W=8)
//   - function make_instr(write, addr)
// - Sub-module ad9361_spi_rr_arb (N_REQ): inputs req vector and last_grant,
//   outputs a one-hot grant plus its index. Purely combinational, used in IDLE.
// - Top level holds the FSM, the request/response registers and the timeout counter
//   ($clog2(TIMEOUT_CYCLES) bits).
// TESTING
// - Single write: port1 write addr 0x037 data 0xA5.
//   -> eng_instr=0x8037, eng_wdata=0xA5, and rsp_valid[1] one cycle after eng_done
//   with rdata=0x00, err=0.
// - Single read: port0 read addr 0x017; engine returns 0x1E.
//   -> eng_instr=0x0017, rsp_rdata=0x1E on rsp_valid[0].
// - Contention: ports 0, 1 and 2 valid together, each holding 2 requests.
//   -> grant order 0,1,2,0,1,2 and no port granted twice in a row.
// - Timeout: TIMEOUT_CYCLES=16, engine never asserts done.
//   -> eng_abort pulse 16 cycles after eng_start, then rsp_valid with err=1, rdata=0.
// - Done on the timeout cycle: eng_done asserted in cycle TIMEOUT_CYCLES-1.
//   -> no eng_abort, err=0, rdata captured.
// - Reset during WAIT: assert reset for 1 cycle.
//   -> all outputs 0, no rsp_valid. The next request from ports 0 and 2 grants port 0 first.

Source files
------------

// File: rtl/ad9361_spi_pkg.sv
// Shared types and instruction-word helpers for the AD9361 SPI arbiter.
package ad9361_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam int INSTR_W       = 16;
    localparam int INSTR_WR_BIT  = 15;
    localparam int INSTR_CNT_LSB = 12;
    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 8;

    // Byte-count field 3'b000 selects a single-byte transfer.
    function automatic logic [INSTR_W-1:0] make_instr(input logic write,
                                                      input logic [ADDR_W-1:0] addr);
        logic [INSTR_W-1:0] instr;
        instr                         = '0;
        instr[INSTR_WR_BIT]           = write;
        instr[INSTR_CNT_LSB +: 3]     = 3'b000;
        instr[ADDR_W-1:0]             = addr;
        return instr;
    endfunction

endpackage

// File: rtl/ad9361_spi_arbiter_if.sv
// Requester and SPI-engine signal bundle; slave = arbiter side, master = environment side.
interface ad9361_spi_arbiter_if #(
    parameter int N_REQ = 3
);
    import ad9361_spi_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    eng_start;
    logic [INSTR_W-1:0]      eng_instr;
    logic [DATA_W-1:0]       eng_wdata;
    logic                    eng_abort;
    logic                    eng_done;
    logic [DATA_W-1:0]       eng_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, eng_done, eng_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               eng_start, eng_instr, eng_wdata, eng_abort
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, eng_done, eng_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               eng_start, eng_instr, eng_wdata, eng_abort
    );

endinterface

// File: rtl/ad9361_spi_rr_arb.sv
// Combinational round-robin picker: first asserted request after last_grant, with wrap.
module ad9361_spi_rr_arb #(
    parameter  int N_REQ = 3,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [IDX_W:0] cand;

    // NOTE: every output and temporary gets a default before the loop, so no path infers a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = {1'b0, last_grant_i} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!any_o && req_i[cand[IDX_W-1:0]]) begin
                any_o                     = 1'b1;
                grant_o[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx_o               = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ad9361_spi_arbiter.sv
// Shares one AD9361 SPI engine among N_REQ requesters: round-robin grant, one byte per transaction, timeout abort.
module ad9361_spi_arbiter
    import ad9361_spi_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ad9361_spi_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   port_q, port_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               write_q, write_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               timeout_hit;

    ad9361_spi_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .any_o        (grant_any)
    );

    assign timeout_hit   = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.eng_instr = instr_q;
    assign bus.eng_wdata = wdata_q;

    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        last_d        = last_q;
        write_d       = write_q;
        instr_d       = instr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        timer_d       = timer_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.eng_start = 1'b0;
        bus.eng_abort = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    bus.req_ready = grant;
                    port_d        = grant_idx;
                    write_d       = bus.req_write[grant_idx];
                    instr_d       = make_instr(bus.req_write[grant_idx],
                                               bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W]);
                    wdata_d       = bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                bus.eng_start = 1'b1;
                timer_d       = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // Completion outranks a timeout landing in the same cycle.
                if (bus.eng_done) begin
                    rdata_d = write_q ? '0 : bus.eng_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    bus.eng_abort = 1'b1;
                    rdata_d       = '0;
                    err_d         = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[port_q] = 1'b1;
                last_d                = port_q;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A transaction interrupted by reset leaves silently: no pulses escape the reset cycle.
        if (rst_i) begin
            bus.req_ready = '0;
            bus.rsp_valid = '0;
            bus.eng_start = 1'b0;
            bus.eng_abort = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            port_q  <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            write_q <= 1'b0;
            instr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            write_q <= write_d;
            instr_q <= instr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_ad9361_spi_arbiter.sv
// Scoreboard bench for ad9361_spi_arbiter: directed requests, behavioural SPI engine, decoupled monitor.
module tb_ad9361_spi_arbiter;
    import ad9361_spi_pkg::*;

    localparam int N  = 3;
    localparam int TO = 16;

    typedef struct { logic write; logic [9:0] addr; logic [7:0] wdata; } req_t;
    typedef struct { logic [15:0] instr; logic [7:0] wdata; } iss_t;
    typedef struct { int port; logic [7:0] rdata; logic err; logic chk_lat; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ad9361_spi_arbiter_if #(.N_REQ(N)) bus ();

    ad9361_spi_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    req_t        port_q [N][$];
    iss_t        iss_q [$];
    rsp_t        rsp_q [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          eng_delay = 2;
    logic [7:0]  eng_data = 8'h00;
    int          abort_exp = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          prev_grant = -1;
    logic [N-1:0] drv_acc;
    req_t        drv_r;
    iss_t        mon_i;
    rsp_t        mon_r;
    int          mon_g;

    assign bus.eng_rdata = eng_data;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy();
        bit b = (iss_q.size() != 0) || (rsp_q.size() != 0) || (bus.req_valid != '0);
        for (int p = 0; p < N; p++) b |= (port_q[p].size() != 0);
        return b;
    endfunction

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_req"}, 64'({bus.req_ready, bus.rsp_valid, bus.eng_start, bus.eng_abort}), 64'(0));
        check({name, "_data"}, 64'({bus.rsp_rdata, bus.rsp_err, bus.eng_instr, bus.eng_wdata}), 64'(0));
    endtask

    // Requester driver: holds valid and fields until accepted, then loads the next queued request.
    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        forever begin
            @(negedge clk);
            drv_acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (drv_acc[p] || !bus.req_valid[p]) begin
                    if (port_q[p].size() > 0) begin
                        drv_r                    = port_q[p].pop_front();
                        bus.req_valid[p]         = 1'b1;
                        bus.req_write[p]         = drv_r.write;
                        bus.req_addr[p*10 +: 10] = drv_r.addr;
                        bus.req_wdata[p*8 +: 8]  = drv_r.wdata;
                    end else begin
                        bus.req_valid[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Engine model: done pulse eng_delay cycles after start; negative delay never completes.
    initial begin
        bus.eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.eng_start && eng_delay >= 0) begin
                repeat (eng_delay) @(posedge clk);
                #1 bus.eng_done = 1'b1;
                @(posedge clk);
                #1 bus.eng_done = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, launch, abort or response.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) prev_grant = -1;
            if (bus.eng_done) done_cyc = cyc;
            if (bus.req_ready != '0) begin
                check("ready_onehot", 64'($onehot(bus.req_ready)), 64'(1));
                mon_g = 0;
                for (int p = 0; p < N; p++) if (bus.req_ready[p]) mon_g = p;
                if (prev_grant >= 0 && (bus.req_valid & ~(N'(1) << prev_grant)) != '0)
                    check("no_repeat_grant", 64'(mon_g == prev_grant), 64'(0));
                prev_grant = mon_g;
            end
            if (bus.eng_start) begin
                start_cyc = cyc;
                if (iss_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: instr 0x%0h", bus.eng_instr);
                end else begin
                    mon_i = iss_q.pop_front();
                    check("eng_instr", 64'(bus.eng_instr), 64'(mon_i.instr));
                    check("eng_wdata", 64'(bus.eng_wdata), 64'(mon_i.wdata));
                end
            end
            if (bus.eng_abort) begin
                if (abort_exp == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_abort: at cycle %0d", cyc);
                end else begin
                    check("abort_latency", 64'(cyc - start_cyc), 64'(TO));
                    abort_exp--;
                end
            end
            if (bus.rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: rsp_valid 0x%0h", bus.rsp_valid);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_port", 64'(bus.rsp_valid), 64'(1) << mon_r.port);
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_r.rdata));
                    check("rsp_err", 64'(bus.rsp_err), 64'(mon_r.err));
                    if (mon_r.chk_lat) check("rsp_latency", 64'(cyc - done_cyc), 64'(1));
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;

        // Single write from port 1.
        eng_delay = 3;
        eng_data  = 8'hC3;
        iss_q.push_back(iss_t'{16'h8037, 8'hA5});
        rsp_q.push_back(rsp_t'{1, 8'h00, 1'b0, 1'b1});
        port_q[1].push_back(req_t'{1'b1, 10'h037, 8'hA5});
        drain("write", 100);

        // Single read from port 0.
        eng_data = 8'h1E;
        iss_q.push_back(iss_t'{16'h0017, 8'h00});
        rsp_q.push_back(rsp_t'{0, 8'h1E, 1'b0, 1'b1});
        port_q[0].push_back(req_t'{1'b0, 10'h017, 8'h00});
        drain("read", 100);

        // Done arrives on the very cycle the timeout would fire.
        eng_delay = TO;
        eng_data  = 8'h6B;
        iss_q.push_back(iss_t'{16'h0066, 8'h00});
        rsp_q.push_back(rsp_t'{1, 8'h6B, 1'b0, 1'b1});
        port_q[1].push_back(req_t'{1'b0, 10'h066, 8'h00});
        drain("done_at_timeout", 100);

        // Engine never completes: abort, error response with zero data.
        eng_delay = -1;
        eng_data  = 8'hFF;
        abort_exp = 1;
        iss_q.push_back(iss_t'{16'h0055, 8'h00});
        rsp_q.push_back(rsp_t'{2, 8'h00, 1'b1, 1'b0});
        port_q[2].push_back(req_t'{1'b0, 10'h055, 8'h00});
        drain("timeout", 100);

        // Contention: last grant was port 2, so service order is 0,1,2,0,1,2.
        eng_delay = 2;
        eng_data  = 8'h5C;
        iss_q.push_back(iss_t'{16'h8100, 8'h11});
        iss_q.push_back(iss_t'{16'h8200, 8'h22});
        iss_q.push_back(iss_t'{16'h8300, 8'h33});
        iss_q.push_back(iss_t'{16'h0101, 8'h00});
        iss_q.push_back(iss_t'{16'h0201, 8'h00});
        iss_q.push_back(iss_t'{16'h0301, 8'h00});
        for (int p = 0; p < N; p++) rsp_q.push_back(rsp_t'{p, 8'h00, 1'b0, 1'b1});
        for (int p = 0; p < N; p++) rsp_q.push_back(rsp_t'{p, 8'h5C, 1'b0, 1'b1});
        port_q[0].push_back(req_t'{1'b1, 10'h100, 8'h11});
        port_q[1].push_back(req_t'{1'b1, 10'h200, 8'h22});
        port_q[2].push_back(req_t'{1'b1, 10'h300, 8'h33});
        port_q[0].push_back(req_t'{1'b0, 10'h101, 8'h00});
        port_q[1].push_back(req_t'{1'b0, 10'h201, 8'h00});
        port_q[2].push_back(req_t'{1'b0, 10'h301, 8'h00});
        drain("contention", 200);

        // Reset while waiting on the engine drops the transaction silently.
        eng_delay = -1;
        iss_q.push_back(iss_t'{16'h8077, 8'h99});
        port_q[0].push_back(req_t'{1'b1, 10'h077, 8'h99});
        n = 0;
        while (iss_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("reset_test_started", 64'(iss_q.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;

        // After reset port 0 wins over port 2.
        eng_delay = 2;
        eng_data  = 8'h42;
        iss_q.push_back(iss_t'{16'h0088, 8'h00});
        iss_q.push_back(iss_t'{16'h8099, 8'h5A});
        rsp_q.push_back(rsp_t'{0, 8'h42, 1'b0, 1'b1});
        rsp_q.push_back(rsp_t'{2, 8'h00, 1'b0, 1'b1});
        port_q[2].push_back(req_t'{1'b1, 10'h099, 8'h5A});
        port_q[0].push_back(req_t'{1'b0, 10'h088, 8'h00});
        drain("post_reset", 100);

        check("aborts_outstanding", 64'(abort_exp), 64'(0));
        check("rsp_outstanding", 64'(rsp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
